// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO and models mult/div latency.
// Results are computed from the operands seen at the start edge and committed when Busy ends.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  output logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic [31:0] E_MDUOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e        state_q;
  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [31:0]   pendHi_q;
  logic [31:0]   pendLo_q;
  logic          pendWr_q;

  logic          isMdOp;
  logic          isDivOp;
  logic [31:0]   resHi_d;
  logic [31:0]   resLo_d;
  logic          resWr_d;

  logic [63:0]   prodS;
  logic [63:0]   prodU;
  logic [31:0]   divisorU;
  logic [31:0]   quotU;
  logic [31:0]   remU;
  logic [31:0]   absRs;
  logic [31:0]   absRt;
  logic [31:0]   qMag;
  logic [31:0]   rMag;

  assign isMdOp  = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU) ||
                   (E_MDUOp == OP_DIV)  || (E_MDUOp == OP_DIVU);
  assign isDivOp = (E_MDUOp == OP_DIV) || (E_MDUOp == OP_DIVU);
  assign E_Start = isMdOp && !busy_q;
  assign E_Busy  = busy_q;
  assign E_HI    = hi_q;
  assign E_LO    = lo_q;

  // Signed divide works on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0.
  // A zero divisor is replaced by 1 purely to keep the dividers defined; its result is discarded.
  always_comb begin
    prodS    = {{32{E_RS[31]}}, E_RS} * {{32{E_RT[31]}}, E_RT};
    prodU    = {32'b0, E_RS} * {32'b0, E_RT};
    divisorU = (E_RT == 32'd0) ? 32'd1 : E_RT;
    quotU    = E_RS / divisorU;
    remU     = E_RS % divisorU;
    absRs    = E_RS[31] ? (32'd0 - E_RS) : E_RS;
    absRt    = E_RT[31] ? (32'd0 - E_RT) : divisorU;
    qMag     = absRs / absRt;
    rMag     = absRs % absRt;

    resHi_d = 32'd0;
    resLo_d = 32'd0;
    resWr_d = 1'b0;
    case (E_MDUOp)
      OP_MULT: begin
        resHi_d = prodS[63:32];
        resLo_d = prodS[31:0];
        resWr_d = 1'b1;
      end
      OP_MULTU: begin
        resHi_d = prodU[63:32];
        resLo_d = prodU[31:0];
        resWr_d = 1'b1;
      end
      OP_DIV: begin
        resLo_d = (E_RS[31] ^ E_RT[31]) ? (32'd0 - qMag) : qMag;
        resHi_d = E_RS[31] ? (32'd0 - rMag) : rMag;
        resWr_d = (E_RT != 32'd0);
      end
      OP_DIVU: begin
        resLo_d = quotU;
        resHi_d = remU;
        resWr_d = (E_RT != 32'd0);
      end
      default: begin
        resHi_d = 32'd0;
        resLo_d = 32'd0;
        resWr_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    E_MDUOut = 32'd0;
    if (E_MDUOp == OP_MFHI) begin
      E_MDUOut = hi_q;
    end else if (E_MDUOp == OP_MFLO) begin
      E_MDUOut = lo_q;
    end
  end

  // Pending results are held until the final Busy edge, so a reset before then drops them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      pendHi_q <= 32'd0;
      pendLo_q <= 32'd0;
      pendWr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (E_Start) begin
            pendHi_q <= resHi_d;
            pendLo_q <= resLo_d;
            pendWr_q <= resWr_d;
            cnt_q    <= isDivOp ? DIV_LOAD : MULT_LOAD;
            busy_q   <= 1'b1;
            state_q  <= BUSY;
          end else if (E_MDUOp == OP_MTHI) begin
            hi_q <= E_RS;
          end else if (E_MDUOp == OP_MTLO) begin
            lo_q <= E_RS;
          end
        end
        BUSY: begin
          if (cnt_q == CNT_ONE) begin
            if (pendWr_q) begin
              hi_q <= pendHi_q;
              lo_q <= pendLo_q;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit.
- Sits beside the ALU and reads the same forwarded E-stage operands: rs value, and the rt register value before the ALU-B source selection.
- Holds the architectural HI/LO registers and models multi-cycle mult/div latency through Start/Busy.
- The hazard unit uses Start/Busy to stall the D stage while an MDU instruction is in flight.
- mfhi/mflo results leave through E_MDUOut into the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, Busy cycles for div/divu (≥1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- E_MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others treated as none
- E_RS  input  32  forwarded rs operand
- E_RT  input  32  forwarded rt operand
- E_Start  output  1  combinational; 1 when E_MDUOp is 1–4 and E_Busy=0
- E_Busy  output  1  registered; 1 while a mult/div is in progress
- E_HI  output  32  current HI register
- E_LO  output  32  current LO register
- E_MDUOut  output  32  combinational; HI when op=5, LO when op=6, else 0

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. Reset at a clock edge gives HI=0, LO=0, E_Busy=0, the internal counter 0 and pending results 0.
- Reset mid-operation aborts the operation. HI/LO are never written with its result.
- States:
  - IDLE (Busy=0). On an edge with E_Start=1, latch the full result into pending HI/LO, load counter = MULT_CYCLES or DIV_CYCLES, and go to BUSY.
  - BUSY (Busy=1). The counter decrements each edge. On the edge where counter==1, copy pending into HI/LO, clear Busy and return to IDLE.
- Timing: if Start is asserted in cycle T, Busy=1 in cycles T+1 … T+N. New HI/LO are visible from cycle T+N+1, so an mfhi in cycle T+N+1 returns the new value.
- Operands are sampled only at the start edge. Later changes on E_RS/E_RT have no effect.
- mult: signed 32×32 → 64; HI=upper, LO=lower.
- multu: unsigned 32×32 → 64; HI=upper, LO=lower.
- div (signed): LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
- div overflow case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned; LO=quotient, HI=remainder.
- Divide by zero (div or divu): the operation still occupies DIV_CYCLES with Busy=1. HI/LO are left unchanged at completion.
- mthi/mtlo: when Busy=0, the edge writes E_RS into HI or LO. Effect is visible the next cycle.
- Operations while Busy=1:
  - mult/div/mthi/mtlo presented during Busy=1 are ignored: no state change and Start stays 0.
  - The hazard unit guarantees this does not happen. The behaviour is still required for robustness.
- mfhi/mflo are purely combinational reads. They are legal only when Busy=0 and Start=0, which the hazard unit enforces.
- Pipeline stalls and flushes of the E stage do not cancel an operation that has already started.

Test Plan:
- mult, E_RS=0xFFFFFFFE (−2), E_RT=3 → Start=1 in T; Busy=1 for T+1..T+5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu, E_RS=0xFFFFFFFF, E_RT=2 → after 5 Busy cycles, HI=0x00000001, LO=0xFFFFFFFE; mflo in T+6 gives E_MDUOut=0xFFFFFFFE.
- div, E_RS=−7 (0xFFFFFFF9), E_RT=2 → Busy 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- divu, 100/7 → LO=14, HI=2. Then div by 0 with HI=2/LO=14 held → Busy 10 cycles, HI/LO still 2/14.
- mthi with E_RS=0x12345678 while idle → HI=0x12345678 next cycle. mtlo presented while Busy=1 → LO unchanged and Start=0.
- Start a div, assert reset in the 4th Busy cycle → next cycle Busy=0, HI=LO=0, and HI/LO stay 0 through the following 10 cycles.
